// File: rtl/dly_multi.sv
// Multi-channel programmable delay: each channel counts ticks from a trigger on
// in[i] and emits a one-cycle out[i] pulse once the count reaches its delay register.
module dly_multi #(
  parameter int NCH    = 4,
  parameter int W      = 8,
  parameter int EDGE   = 1,
  parameter int RETRIG = 0,
  parameter int DLY0   = 5,
  localparam int LW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] in,
  input  logic [NCH-1:0] abort,
  input  logic           ld,
  input  logic [LW-1:0]  ld_ch,
  input  logic [W-1:0]   ld_val,
  output logic [NCH-1:0] active,
  output logic [NCH-1:0] out,
  output logic           busy
);

  logic [1:0]     init;
  logic [NCH-1:0] cnt_nz;

  // Triggers stay blocked until init has filled with ones, two edges after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) init <= 2'b00;
    else       init <= {init[0], 1'b1};
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [W-1:0] cnt;
    logic [W-1:0] dly;
    logic         in_q;
    logic         nz;
    logic         hit;
    logic         trig;

    assign nz   = (cnt != '0);
    assign hit  = (EDGE != 0) ? (in[i] & ~in_q) : in[i];
    assign trig = hit & (init == 2'b11) & (dly != '0);

    // Compare with >= so a delay lowered below the running count still fires.
    assign out[i]    = nz & (cnt >= dly);
    assign active[i] = nz & ~out[i];
    assign cnt_nz[i] = nz;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt  <= '0;
        dly  <= W'(DLY0);
        in_q <= 1'b0;
      end else begin
        in_q <= in[i];
        if (ld && (ld_ch == LW'(i))) dly <= ld_val;
        if (abort[i] || out[i])               cnt <= '0;
        else if (trig && (!nz || RETRIG != 0)) cnt <= W'(1);
        else if (nz)                          cnt <= cnt + W'(1);
      end
    end
  end

  assign busy = |cnt_nz;

endmodule

// File: tb/tb_dly_multi.sv
// Directed bench for dly_multi: four instances (defaults, retrigger, level mode, NCH=3);
// expected out pulses are queued by the stimulus and matched by an independent monitor.
module tb_dly_multi;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Edge number since reset release: edge 1 is the first rising edge after release.
  int ecount;
  always @(posedge clk or posedge reset) begin
    if (reset) ecount <= 0;
    else       ecount <= ecount + 1;
  end

  logic [3:0] a_in, a_abort, a_active, a_out;
  logic       a_ld, a_busy;
  logic [1:0] a_ld_ch;
  logic [7:0] a_ld_val;
  logic [3:0] b_in, b_abort, b_active, b_out;
  logic       b_ld, b_busy;
  logic [1:0] b_ld_ch;
  logic [7:0] b_ld_val;
  logic [3:0] c_in, c_abort, c_active, c_out;
  logic       c_ld, c_busy;
  logic [1:0] c_ld_ch;
  logic [7:0] c_ld_val;
  logic [2:0] d_in, d_abort, d_active, d_out;
  logic       d_ld, d_busy;
  logic [1:0] d_ld_ch;
  logic [7:0] d_ld_val;

  dly_multi u_a (.clk(clk), .reset(reset), .in(a_in), .abort(a_abort), .ld(a_ld),
                 .ld_ch(a_ld_ch), .ld_val(a_ld_val), .active(a_active), .out(a_out), .busy(a_busy));
  dly_multi #(.RETRIG(1)) u_b (.clk(clk), .reset(reset), .in(b_in), .abort(b_abort), .ld(b_ld),
                 .ld_ch(b_ld_ch), .ld_val(b_ld_val), .active(b_active), .out(b_out), .busy(b_busy));
  dly_multi #(.EDGE(0)) u_c (.clk(clk), .reset(reset), .in(c_in), .abort(c_abort), .ld(c_ld),
                 .ld_ch(c_ld_ch), .ld_val(c_ld_val), .active(c_active), .out(c_out), .busy(c_busy));
  dly_multi #(.NCH(3)) u_d (.clk(clk), .reset(reset), .in(d_in), .abort(d_abort), .ld(d_ld),
                 .ld_ch(d_ld_ch), .ld_val(d_ld_val), .active(d_active), .out(d_out), .busy(d_busy));

  logic [3:0] outs [4];
  assign outs[0] = a_out;
  assign outs[1] = b_out;
  assign outs[2] = c_out;
  assign outs[3] = {1'b0, d_out};

  // Entry layout: {dut[3:0], channel[3:0], edge number[23:0]}.
  localparam int EW = 32;
  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (edge %0d)", name, got, exp, ecount);
    end
  endtask

  task automatic expect_pulse(input int d, input int c, input int e);
    exp_q.push_back({4'(d), 4'(c), 24'(e)});
  endtask

  task automatic match_pulse(input int d, input int c);
    int idx = -1;
    for (int k = 0; k < exp_q.size(); k++)
      if (idx < 0 && exp_q[k][31:28] == 4'(d) && exp_q[k][27:24] == 4'(c)) idx = k;
    n_cmp++;
    if (idx < 0) begin
      n_fail++;
      $display("FAIL pulse_unexpected: dut %0d ch %0d pulsed after edge %0d, required no pulse", d, c, ecount);
    end else begin
      if (exp_q[idx][23:0] != 24'(ecount)) begin
        n_fail++;
        $display("FAIL pulse_time: dut %0d ch %0d pulsed after edge %0d, required edge %0d",
                 d, c, ecount, exp_q[idx][23:0]);
      end
      exp_q.delete(idx);
    end
  endtask

  always @(negedge clk) begin
    if (!reset)
      for (int d = 0; d < 4; d++)
        for (int c = 0; c < 4; c++)
          if (outs[d][c]) match_pulse(d, c);
  end

  // Park at the falling edge where ecount == n; inputs set here are seen at edge n+1.
  task automatic goto(input int n);
    int guard = 0;
    while (ecount != n && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) begin
      n_cmp++;
      n_fail++;
      $display("FAIL goto_timeout: edge %0d, required %0d", ecount, n);
    end
  endtask

  task automatic start_reset();
    reset = 1'b1;
    a_in = '0; a_abort = '0; a_ld = 1'b0; a_ld_ch = '0; a_ld_val = '0;
    b_in = '0; b_abort = '0; b_ld = 1'b0; b_ld_ch = '0; b_ld_val = '0;
    c_in = '0; c_abort = '0; c_ld = 1'b0; c_ld_ch = '0; c_ld_val = '0;
    d_in = '0; d_abort = '0; d_ld = 1'b0; d_ld_ch = '0; d_ld_val = '0;
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    chk("rst_out", {a_out, b_out, c_out, 1'b0, d_out}, 32'h0);
    chk("rst_active", {a_active, b_active, c_active, 1'b0, d_active}, 32'h0);
    chk("rst_busy", {a_busy, b_busy, c_busy, d_busy}, 32'h0);
    reset = 1'b0;
  endtask

  task automatic end_phase(input string name);
    goto(30);
    while (exp_q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL pulse_missing %s: dut %0d ch %0d expected after edge %0d, never pulsed",
               name, exp_q[0][31:28], exp_q[0][27:24], exp_q[0][23:0]);
      void'(exp_q.pop_front());
    end
  endtask

  initial begin
    start_reset();

    // Basic edge trigger on ch0; ch1 held high through reset must not fire, then re-armed.
    a_in[1] = 1'b1;
    release_reset();
    goto(9);  a_in[0] = 1'b1; expect_pulse(0, 0, 14);
    chk("p1_active_pre", 32'(a_active[0]), 0);
    for (int e = 10; e <= 14; e++) begin
      goto(e);
      chk("p1_active", 32'(a_active[0]), (e <= 13) ? 1 : 0);
    end
    chk("p1_busy_out", 32'(a_busy), 1);
    goto(15); chk("p1_busy_done", 32'(a_busy), 0);
    goto(16); a_in = 4'b0000;
    goto(19); a_in[1] = 1'b1; expect_pulse(0, 1, 24);
    end_phase("basic");

    // Same double trigger into RETRIG=0 (u_a) and RETRIG=1 (u_b).
    start_reset();
    release_reset();
    goto(9);  a_in[0] = 1'b1; b_in[0] = 1'b1;
    expect_pulse(0, 0, 14); expect_pulse(1, 0, 16);
    goto(10); a_in[0] = 1'b0; b_in[0] = 1'b0;
    goto(11); a_in[0] = 1'b1; b_in[0] = 1'b1;
    goto(12); a_in[0] = 1'b0; b_in[0] = 1'b0;
    chk("p2_active_b", 32'(b_active[0]), 1);
    end_phase("retrig");

    // Delay lowered to 2 while cnt is 3; load to ld_ch=3 on a 3-channel block is dropped.
    start_reset();
    release_reset();
    goto(4);  d_ld = 1'b1; d_ld_ch = 2'd3; d_ld_val = 8'd1;
    goto(5);  d_ld = 1'b0;
    goto(9);  a_in[0] = 1'b1; d_in = 3'b101;
    expect_pulse(3, 0, 14); expect_pulse(3, 2, 14);
    goto(12); a_ld = 1'b1; a_ld_ch = 2'd0; a_ld_val = 8'd2; expect_pulse(0, 0, 13);
    chk("p3_active_pre_ld", 32'(a_active[0]), 1);
    goto(13); a_ld = 1'b0;
    goto(14); chk("p3_busy", 32'(a_busy), 0);
    end_phase("load");

    // All four channels at once; ch2 aborted at edge 12.
    start_reset();
    release_reset();
    goto(9);  a_in = 4'b1111;
    expect_pulse(0, 0, 14); expect_pulse(0, 1, 14); expect_pulse(0, 3, 14);
    goto(11); a_abort[2] = 1'b1;
    chk("p4_active_all", 32'(a_active), 32'hf);
    goto(12); a_abort[2] = 1'b0;
    chk("p4_active_abort", 32'(a_active), 32'hb);
    end_phase("abort");

    // Reset mid-count discards it and restores DLY0 on ch3.
    start_reset();
    release_reset();
    goto(4);  a_ld = 1'b1; a_ld_ch = 2'd3; a_ld_val = 8'd7;
    goto(5);  a_ld = 1'b0;
    goto(9);  a_in[3] = 1'b1;
    goto(11);
    chk("p5_active_run", 32'(a_active[3]), 1);
    reset = 1'b1;
    #1;
    chk("p5_rst_async", {a_out, a_active, 3'b000, a_busy}, 32'h0);
    a_in = '0;
    release_reset();
    goto(20);
    chk("p5_idle", {a_active, a_busy}, 32'h0);
    start_reset();
    release_reset();
    goto(9);  a_in[3] = 1'b1; expect_pulse(0, 3, 14);
    goto(13); chk("p5_active_dly0", 32'(a_active[3]), 1);
    end_phase("reset");

    // dly=0 disables ch0; dly=1 on ch1 fires right after the trigger edge.
    start_reset();
    release_reset();
    goto(4);  a_ld = 1'b1; a_ld_ch = 2'd0; a_ld_val = 8'd0;
    goto(5);  a_ld_ch = 2'd1; a_ld_val = 8'd1;
    goto(6);  a_ld = 1'b0;
    goto(9);  a_in[1:0] = 2'b11; expect_pulse(0, 1, 10);
    goto(10); chk("p6_active", 32'(a_active[1:0]), 0);
    goto(11); chk("p6_busy", 32'(a_busy), 0);
    end_phase("dly0");

    // Level mode, in held high, D=3: pulse every 4 cycles.
    start_reset();
    c_in[0] = 1'b1;
    release_reset();
    goto(1);  c_ld = 1'b1; c_ld_ch = 2'd0; c_ld_val = 8'd3;
    goto(2);  c_ld = 1'b0;
    for (int k = 0; k < 5; k++) expect_pulse(2, 0, 5 + 4 * k);
    goto(6);  chk("p7_gap", 32'(c_active[0]), 0);
    goto(22); c_in[0] = 1'b0;
    end_phase("level");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
